// File: rtl/fp_add_arbiter_if.sv
// Connection bundle for fp_add_arbiter: two requester channels, the adder port, result returns, flush and busy.
// The FP_ARB_STATS_EN macro adds the grant and conflict counters to the bundle.
interface fp_add_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;
    logic             flush;
    logic             add_valid;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_sub;
    logic [WIDTH-1:0] add_result;
    logic             resp0_valid;
    logic [WIDTH-1:0] resp0_result;
    logic             resp1_valid;
    logic [WIDTH-1:0] resp1_result;
    logic             busy;
`ifdef FP_ARB_STATS_EN
    logic [31:0]      grant0_cnt;
    logic [31:0]      grant1_cnt;
    logic [31:0]      conflict_cnt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  flush, add_result,
        output req0_ready, req1_ready,
        output add_valid, add_a, add_b, add_sub,
        output resp0_valid, resp0_result, resp1_valid, resp1_result, busy,
        output grant0_cnt, grant1_cnt, conflict_cnt
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output flush, add_result,
        input  req0_ready, req1_ready,
        input  add_valid, add_a, add_b, add_sub,
        input  resp0_valid, resp0_result, resp1_valid, resp1_result, busy,
        input  grant0_cnt, grant1_cnt, conflict_cnt
    );
`else
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  flush, add_result,
        output req0_ready, req1_ready,
        output add_valid, add_a, add_b, add_sub,
        output resp0_valid, resp0_result, resp1_valid, resp1_result, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output flush, add_result,
        input  req0_ready, req1_ready,
        input  add_valid, add_a, add_b, add_sub,
        input  resp0_valid, resp0_result, resp1_valid, resp1_result, busy
    );
`endif
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one pipelined FP adder between two requesters, with owner tags routing results back.
// Define FP_ARB_STATS_EN to add grant/conflict statistics counters.
module fp_add_arbiter #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 3
) (
    input logic             clk,
    input logic             rst,
    fp_add_arbiter_if.slave bus
);

    logic               gnt0_s;
    logic               gnt1_s;
    logic               tail_vld_s;
    logic               last_grant_q,   last_grant_d;
    logic               add_valid_q,    add_valid_d;
    logic [WIDTH-1:0]   add_a_q,        add_a_d;
    logic [WIDTH-1:0]   add_b_q,        add_b_d;
    logic               add_sub_q,      add_sub_d;
    logic               add_owner_q,    add_owner_d;
    logic [LATENCY-1:0] tag_vld_q,      tag_vld_d;
    logic [LATENCY-1:0] tag_own_q,      tag_own_d;
    logic               resp0_valid_q,  resp0_valid_d;
    logic               resp1_valid_q,  resp1_valid_d;
    logic [WIDTH-1:0]   resp0_result_q, resp0_result_d;
    logic [WIDTH-1:0]   resp1_result_q, resp1_result_d;

    // Grant: on a tie the requester that did not win last time goes next.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst || bus.flush) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.req0_valid && bus.req1_valid) begin
            gnt0_s = last_grant_q;
            gnt1_s = ~last_grant_q;
        end else begin
            gnt0_s = bus.req0_valid;
            gnt1_s = bus.req1_valid;
        end
    end

    assign tail_vld_s = tag_vld_q[LATENCY-1] & ~bus.flush;

    // Next state of the issue register, owner tag pipeline and response registers.
    always_comb begin
        last_grant_d = last_grant_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_sub_d    = add_sub_q;
        add_owner_d  = add_owner_q;
        add_valid_d  = gnt0_s | gnt1_s;
        if (gnt1_s) begin
            last_grant_d = 1'b1;
            add_a_d      = bus.req1_a;
            add_b_d      = bus.req1_b;
            add_sub_d    = bus.req1_sub;
            add_owner_d  = 1'b1;
        end else if (gnt0_s) begin
            last_grant_d = 1'b0;
            add_a_d      = bus.req0_a;
            add_b_d      = bus.req0_b;
            add_sub_d    = bus.req0_sub;
            add_owner_d  = 1'b0;
        end else begin
            last_grant_d = last_grant_q;
        end

        tag_vld_d    = {LATENCY{1'b0}};
        tag_own_d    = {LATENCY{1'b0}};
        tag_vld_d[0] = add_valid_q & ~bus.flush;
        tag_own_d[0] = add_owner_q;
        for (int i = 1; i < LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1] & ~bus.flush;
            tag_own_d[i] = tag_own_q[i-1];
        end

        resp0_valid_d = tail_vld_s & ~tag_own_q[LATENCY-1];
        resp1_valid_d = tail_vld_s &  tag_own_q[LATENCY-1];
        if (resp0_valid_d) begin
            resp0_result_d = bus.add_result;
        end else begin
            resp0_result_d = resp0_result_q;
        end
        if (resp1_valid_d) begin
            resp1_result_d = bus.add_result;
        end else begin
            resp1_result_d = resp1_result_q;
        end
    end

    // State registers; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q   <= 1'b1;
            add_valid_q    <= 1'b0;
            add_a_q        <= {WIDTH{1'b0}};
            add_b_q        <= {WIDTH{1'b0}};
            add_sub_q      <= 1'b0;
            add_owner_q    <= 1'b0;
            tag_vld_q      <= {LATENCY{1'b0}};
            tag_own_q      <= {LATENCY{1'b0}};
            resp0_valid_q  <= 1'b0;
            resp1_valid_q  <= 1'b0;
            resp0_result_q <= {WIDTH{1'b0}};
            resp1_result_q <= {WIDTH{1'b0}};
        end else begin
            last_grant_q   <= last_grant_d;
            add_valid_q    <= add_valid_d;
            add_a_q        <= add_a_d;
            add_b_q        <= add_b_d;
            add_sub_q      <= add_sub_d;
            add_owner_q    <= add_owner_d;
            tag_vld_q      <= tag_vld_d;
            tag_own_q      <= tag_own_d;
            resp0_valid_q  <= resp0_valid_d;
            resp1_valid_q  <= resp1_valid_d;
            resp0_result_q <= resp0_result_d;
            resp1_result_q <= resp1_result_d;
        end
    end

    assign bus.req0_ready   = gnt0_s;
    assign bus.req1_ready   = gnt1_s;
    assign bus.add_valid    = add_valid_q;
    assign bus.add_a        = add_a_q;
    assign bus.add_b        = add_b_q;
    assign bus.add_sub      = add_sub_q;
    assign bus.resp0_valid  = resp0_valid_q;
    assign bus.resp0_result = resp0_result_q;
    assign bus.resp1_valid  = resp1_valid_q;
    assign bus.resp1_result = resp1_result_q;
    assign bus.busy         = add_valid_q | (|tag_vld_q) | resp0_valid_q | resp1_valid_q;

`ifdef FP_ARB_STATS_EN
    logic [31:0] grant0_cnt_q,   grant0_cnt_d;
    logic [31:0] grant1_cnt_q,   grant1_cnt_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    // Statistics counters wrap naturally at 2^32.
    always_comb begin
        grant0_cnt_d   = grant0_cnt_q + {31'd0, gnt0_s};
        grant1_cnt_d   = grant1_cnt_q + {31'd0, gnt1_s};
        conflict_cnt_d = conflict_cnt_q
                       + {31'd0, bus.req0_valid & bus.req1_valid & ~bus.flush};
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_cnt_q   <= 32'd0;
            grant1_cnt_q   <= 32'd0;
            conflict_cnt_q <= 32'd0;
        end else begin
            grant0_cnt_q   <= grant0_cnt_d;
            grant1_cnt_q   <= grant1_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.grant0_cnt   = grant0_cnt_q;
    assign bus.grant1_cnt   = grant1_cnt_q;
    assign bus.conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: directed scenarios plus randomized traffic, with a delay-line adder model.
module tb_fp_add_arbiter;
    localparam int W   = 64;
    localparam int LAT = 3;

    typedef struct {
        int          due;
        bit          owner;
        logic [63:0] res;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    int          cyc    = 0;
    int          n_vec  = 0;
    int          n_err  = 0;
    bit          chk_en = 1'b0;
    exp_t        sb[$];

    logic        m_next = 1'b0;
    logic        m_av   = 1'b0;
    logic [63:0] m_a    = 64'd0;
    logic [63:0] m_b    = 64'd0;
    logic        m_sub  = 1'b0;
    logic [63:0] m_res0 = 64'd0;
    logic [63:0] m_res1 = 64'd0;

    bit          hv [32];
    logic [63:0] hr [32];

    fp_add_arbiter_if #(.WIDTH(W)) bus ();

    fp_add_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b, input logic sub);
        real ra, rb;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        return sub ? $realtobits(ra - rb) : $realtobits(ra + rb);
    endfunction

    function automatic logic [63:0] rnd_op();
        int v;
        v = int'($urandom_range(0, 4000)) - 2000;
        return $realtobits(real'(v) * 0.125);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Adder model: the result appears exactly LAT cycles after add_valid, noise otherwise.
    always @(negedge clk) begin
        hv[cyc % 32] = (bus.add_valid === 1'b1);
        hr[cyc % 32] = fadd(bus.add_a, bus.add_b, bus.add_sub);
        if (cyc >= LAT && hv[(cyc - LAT) % 32])
            bus.add_result = hr[(cyc - LAT) % 32];
        else
            bus.add_result = {$urandom, $urandom};
    end

    // Monitor: reference arbitration, expected issue register, scoreboard pop and push.
    always @(negedge clk) begin : monitor
        logic g0, g1, blk, h0, h1;
        exp_t e;
        blk = rst | bus.flush;
        g0  = 1'b0;
        g1  = 1'b0;
        if (!blk && bus.req0_valid && bus.req1_valid) begin
            g0 = (m_next == 1'b0);
            g1 = ~g0;
        end else if (!blk) begin
            g0 = bus.req0_valid;
            g1 = bus.req1_valid;
        end
        h0 = 1'b0;
        h1 = 1'b0;
        if (chk_en) begin
            check("req0_ready", bus.req0_ready, g0);
            check("req1_ready", bus.req1_ready, g1);
            check("add_valid", bus.add_valid, m_av);
            check("add_a", bus.add_a, m_a);
            check("add_b", bus.add_b, m_b);
            check("add_sub", bus.add_sub, m_sub);
            check("busy", bus.busy, (sb.size() > 0) ? 64'd1 : 64'd0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (e.owner) begin
                    h1 = 1'b1;
                    m_res1 = e.res;
                end else begin
                    h0 = 1'b1;
                    m_res0 = e.res;
                end
            end
            check("resp0_valid", bus.resp0_valid, h0);
            check("resp1_valid", bus.resp1_valid, h1);
            check("resp0_result", bus.resp0_result, m_res0);
            check("resp1_result", bus.resp1_result, m_res1);
        end
        m_av = g0 | g1;
        if (g0) begin
            sb.push_back('{due: cyc + LAT + 2, owner: 1'b0, res: fadd(bus.req0_a, bus.req0_b, bus.req0_sub)});
            m_a = bus.req0_a; m_b = bus.req0_b; m_sub = bus.req0_sub; m_next = 1'b1;
        end else if (g1) begin
            sb.push_back('{due: cyc + LAT + 2, owner: 1'b1, res: fadd(bus.req1_a, bus.req1_b, bus.req1_sub)});
            m_a = bus.req1_a; m_b = bus.req1_b; m_sub = bus.req1_sub; m_next = 1'b0;
        end
        if (blk) sb.delete();
        if (rst) begin
            m_next = 1'b0; m_av = 1'b0; m_a = 64'd0; m_b = 64'd0; m_sub = 1'b0;
            m_res0 = 64'd0; m_res1 = 64'd0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic set_req(input int n, input logic v);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_a = rnd_op(); bus.req0_b = rnd_op(); bus.req0_sub = 1'($urandom_range(0, 1));
        end else begin
            bus.req1_valid = v; bus.req1_a = rnd_op(); bus.req1_b = rnd_op(); bus.req1_sub = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle_inputs();
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_add_valid"}, bus.add_valid, 64'd0);
        check({tag, "_add_a"}, bus.add_a, 64'd0);
        check({tag, "_add_b"}, bus.add_b, 64'd0);
        check({tag, "_resp0_valid"}, bus.resp0_valid, 64'd0);
        check({tag, "_resp1_valid"}, bus.resp1_valid, 64'd0);
        check({tag, "_resp0_result"}, bus.resp0_result, 64'd0);
        check({tag, "_resp1_result"}, bus.resp1_result, 64'd0);
        check({tag, "_busy"}, bus.busy, 64'd0);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < lim) begin
            step();
            n++;
        end
        check("drain", bus.busy, 64'd0);
    endtask

    initial begin
        logic acc0, acc1;
        idle_inputs();
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        do_reset(2);
        chk_en = 1'b1;
        check_zero("reset");

        // Scenario 1: single add on requester 0.
        bus.req0_valid = 1'b1;
        bus.req0_a = 64'h3FF0000000000000; bus.req0_b = 64'h4000000000000000; bus.req0_sub = 1'b0;
        step();
        bus.req0_valid = 1'b0;
        check("s1_add_valid", bus.add_valid, 64'd1);
        check("s1_add_a", bus.add_a, 64'h3FF0000000000000);
        repeat (4) step();
        check("s1_resp0_valid", bus.resp0_valid, 64'd1);
        check("s1_resp0_result", bus.resp0_result, 64'h4008000000000000);
        wait_idle(40);

        // Scenario 2: both requesters held valid for 6 cycles after reset.
        do_reset(1);
`ifdef FP_ARB_STATS_EN
        check("stat0_reset", bus.grant0_cnt, 64'd0);
        check("conflict_reset", bus.conflict_cnt, 64'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1);
            set_req(1, 1'b1);
            #1;
            check("s2_ready0", bus.req0_ready, (i % 2 == 0) ? 64'd1 : 64'd0);
            step();
        end
        idle_inputs();
        wait_idle(40);
`ifdef FP_ARB_STATS_EN
        check("grant0_cnt", bus.grant0_cnt, 64'd3);
        check("grant1_cnt", bus.grant1_cnt, 64'd3);
        check("conflict_cnt", bus.conflict_cnt, 64'd6);
`endif

        // Scenario 3: requester 1 streaming 8 operations.
        for (int i = 0; i < 8; i++) begin
            set_req(1, 1'b1);
            #1;
            check("s3_ready1", bus.req1_ready, 64'd1);
            step();
        end
        idle_inputs();
        wait_idle(40);

        // Scenario 4: three ops, then flush squashes them all.
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1);
            step();
        end
        idle_inputs();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("s4_busy", bus.busy, 64'd0);
        set_req(0, 1'b1);
        #1;
        check("s4_ready0", bus.req0_ready, 64'd1);
        step();
        idle_inputs();
        wait_idle(40);

        // Scenario 5: a tie under flush leaves the rotation untouched.
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        #1;
        check("s5_tie1_ready1", bus.req1_ready, 64'd1);
        step();
        bus.flush = 1'b1;
        #1;
        check("s5_flush_ready0", bus.req0_ready, 64'd0);
        check("s5_flush_ready1", bus.req1_ready, 64'd0);
        step();
        bus.flush = 1'b0;
        #1;
        check("s5_tie2_ready0", bus.req0_ready, 64'd1);
        step();
        idle_inputs();
        wait_idle(40);

        // Scenario 6: reset with two operations in flight.
        set_req(1, 1'b1);
        step();
        set_req(1, 1'b1);
        step();
        do_reset(1);
        check_zero("s6");
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        #1;
        check("s6_tie_ready0", bus.req0_ready, 64'd1);
        step();
        idle_inputs();
        repeat (8) step();

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            acc0 = bus.req0_valid & bus.req0_ready;
            acc1 = bus.req1_valid & bus.req1_ready;
            step();
            if (!bus.req0_valid || acc0) set_req(0, 1'($urandom_range(0, 99) < 60));
            if (!bus.req1_valid || acc1) set_req(1, 1'($urandom_range(0, 99) < 60));
            bus.flush = 1'($urandom_range(0, 99) < 4);
            rst       = 1'($urandom_range(0, 99) < 1);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        wait_idle(40);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
